// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: the symbolic op enumeration, the major opcodes, funct3/funct7 values,
// and helpers that map an op to its instruction format and function fields.
package rv32_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [5:0] {
        OP_NOP = 6'd0,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_JAL, OP_LUI, OP_AUIPC, OP_JALR
    } rv32_op_e;

    typedef enum logic [3:0] {
        CLS_NONE, CLS_R, CLS_I, CLS_SH, CLS_LD, CLS_ST,
        CLS_BR, CLS_JAL, CLS_U, CLS_JALR, CLS_BAD
    } op_class_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [2:0] F3_SB = 3'd0;
    localparam logic [2:0] F3_SH = 3'd1;
    localparam logic [2:0] F3_SW = 3'd2;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    function automatic op_class_e op_class(input logic [5:0] op);
        case (op)
            OP_NOP:                                           return CLS_NONE;
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
            OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND:            return CLS_R;
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI,
            OP_ANDI:                                          return CLS_I;
            OP_SLLI, OP_SRLI, OP_SRAI:                        return CLS_SH;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:              return CLS_LD;
            OP_SB, OP_SH, OP_SW:                              return CLS_ST;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: return CLS_BR;
            OP_JAL:                                           return CLS_JAL;
            OP_LUI, OP_AUIPC:                                 return CLS_U;
            OP_JALR:                                          return CLS_JALR;
            default:                                          return CLS_BAD;
        endcase
    endfunction

    function automatic logic [2:0] op_f3(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDI:              return F3_ADD;
            OP_SLL, OP_SLLI:                      return F3_SLL;
            OP_SLT, OP_SLTI:                      return F3_SLT;
            OP_SLTU, OP_SLTIU:                    return F3_SLTU;
            OP_XOR, OP_XORI:                      return F3_XOR;
            OP_SRL, OP_SRA, OP_SRLI, OP_SRAI:     return F3_SR;
            OP_OR, OP_ORI:                        return F3_OR;
            OP_AND, OP_ANDI:                      return F3_AND;
            OP_LB:                                return F3_LB;
            OP_LH:                                return F3_LH;
            OP_LW:                                return F3_LW;
            OP_LBU:                               return F3_LBU;
            OP_LHU:                               return F3_LHU;
            OP_SB:                                return F3_SB;
            OP_SH:                                return F3_SH;
            OP_SW:                                return F3_SW;
            OP_BEQ:                               return F3_BEQ;
            OP_BNE:                               return F3_BNE;
            OP_BLT:                               return F3_BLT;
            OP_BGE:                               return F3_BGE;
            OP_BLTU:                              return F3_BLTU;
            OP_BGEU:                              return F3_BGEU;
            default:                              return 3'd0;
        endcase
    endfunction

    function automatic logic [6:0] op_f7(input logic [5:0] op);
        case (op)
            OP_SUB, OP_SRA, OP_SRAI: return F7_ALT;
            default:                 return F7_BASE;
        endcase
    endfunction

endpackage

// File: rtl/rv32_encode_comb.sv
// Purely combinational op/fields -> {RV32I word, illegal}; unused fields are forced to zero.
// Immediate range checking is compiled in only when RANGE_CHECK_EN is defined.
module rv32_encode_comb
    import rv32_pkg::*;
(
    input  logic [5:0]         op_i,
    input  logic [4:0]         rd_i,
    input  logic [4:0]         rs1_i,
    input  logic [4:0]         rs2_i,
    input  logic [31:0]        imm_i,
    output logic [INSTR_W-1:0] word_o,
    output logic               illegal_o
);

    op_class_e  cls;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       imm_bad;

    assign cls = op_class(op_i);
    assign f3  = op_f3(op_i);
    assign f7  = op_f7(op_i);

    always_comb begin
        word_o = '0;
        case (cls)
            CLS_R:    word_o = {f7, rs2_i, rs1_i, f3, rd_i, OPC_OP};
            CLS_I:    word_o = {imm_i[11:0], rs1_i, f3, rd_i, OPC_OP_IMM};
            CLS_SH:   word_o = {f7, imm_i[4:0], rs1_i, f3, rd_i, OPC_OP_IMM};
            CLS_LD:   word_o = {imm_i[11:0], rs1_i, f3, rd_i, OPC_LOAD};
            CLS_ST:   word_o = {imm_i[11:5], rs2_i, rs1_i, f3, imm_i[4:0], OPC_STORE};
            CLS_BR:   word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3,
                                imm_i[4:1], imm_i[11], OPC_BRANCH};
            CLS_JAL:  word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
            CLS_U:    word_o = {imm_i[31:12], rd_i, (op_i == OP_LUI) ? OPC_LUI : OPC_AUIPC};
            CLS_JALR: word_o = {imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_JALR};
            default:  word_o = '0;
        endcase
    end

`ifdef RANGE_CHECK_EN
    logic signed [31:0] simm;
    assign simm = $signed(imm_i);

    // Offsets must fit the encoded field exactly; branch/jump targets must also be halfword aligned.
    always_comb begin
        imm_bad = 1'b0;
        case (cls)
            CLS_I, CLS_LD, CLS_ST, CLS_JALR:
                imm_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
            CLS_SH:
                imm_bad = (imm_i[31:5] != 27'd0);
            CLS_BR:
                imm_bad = (simm < -32'sd4096) || (simm > 32'sd4094) || imm_i[0];
            CLS_JAL:
                imm_bad = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm_i[0];
            CLS_U:
                imm_bad = (imm_i[11:0] != 12'd0);
            default:
                imm_bad = 1'b0;
        endcase
    end
`else
    assign imm_bad = 1'b0;
`endif

    assign illegal_o = (cls == CLS_BAD) || imm_bad;

endmodule

// File: rtl/rv32_instr_encoder.sv
// RV32I instruction encoder / program loader: encodes a request and writes it to the next word.
// Latency: transfer in cycle N -> mem_we in N+1, one per cycle; req_ready drops while full or on start.
// Optional immediate range checking: define RANGE_CHECK_EN.
module rv32_instr_encoder
    import rv32_pkg::*;
#(
    parameter int          AW        = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          DEPTH     = 256
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [5:0]         req_op,
    input  logic [4:0]         req_rd,
    input  logic [4:0]         req_rs1,
    input  logic [4:0]         req_rs2,
    input  logic [31:0]        req_imm,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic [AW:0]        count,
    output logic               full,
    output logic               err
);

    localparam logic [AW-1:0] BASE    = AW'(BASE_ADDR);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    logic [INSTR_W-1:0] enc_word;
    logic               enc_illegal;
    logic               xfer;

    logic               we_q, we_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic [AW-1:0]      ptr_q, ptr_d;
    logic [AW:0]        cnt_q, cnt_d;
    logic               err_q, err_d;

    rv32_encode_comb u_encode (
        .op_i      (req_op),
        .rd_i      (req_rd),
        .rs1_i     (req_rs1),
        .rs2_i     (req_rs2),
        .imm_i     (req_imm),
        .word_o    (enc_word),
        .illegal_o (enc_illegal)
    );

    assign full      = (cnt_q == DEPTH_C);
    assign req_ready = !full && !start;
    assign xfer      = req_valid && req_ready;

    // Legality is known at transfer time, so count/full advance on the same edge that raises mem_we;
    // that is what lets full block the request right after the last accepted write.
    always_comb begin
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (start) begin
            ptr_d = BASE;
            cnt_d = '0;
            err_d = 1'b0;
        end else if (xfer) begin
            if (enc_illegal) begin
                err_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                wdata_d = enc_word;
                ptr_d   = ptr_q + 1'b1;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= BASE;
            wdata_q <= '0;
            ptr_q   <= BASE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Directed + randomized bench for rv32_instr_encoder (DEPTH=4) against an arithmetic reference encoder.
module tb_rv32_instr_encoder;
    import rv32_pkg::*;

    localparam int AW    = 8;
    localparam int BASE  = 0;
    localparam int DEPTH = 4;

    logic          clock;
    logic          reset;
    logic          start;
    logic          req_valid;
    logic          req_ready;
    logic [5:0]    req_op;
    logic [4:0]    req_rd;
    logic [4:0]    req_rs1;
    logic [4:0]    req_rs2;
    logic [31:0]   req_imm;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;
    logic          full;
    logic          err;

    rv32_instr_encoder #(.AW(AW), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rd    (req_rd),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_imm   (req_imm),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .full      (full),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int m_ptr;
    int m_cnt;
    bit m_err;

    int r_f3[10]  = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int i_f3[9]   = '{0, 2, 3, 4, 6, 7, 1, 5, 5};
    int ld_f3[5]  = '{0, 1, 2, 4, 5};
    int br_f3[6]  = '{0, 1, 4, 5, 6, 7};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void ref_encode(input int op, input int unsigned rd, input int unsigned rs1,
                                       input int unsigned rs2, input logic [31:0] imm,
                                       output int unsigned w, output bit legal);
        int unsigned u;
        int          s;
        int unsigned f7;
        bit          rc;
        u = imm;
        s = $signed(imm);
        rc = 1'b0;
`ifdef RANGE_CHECK_EN
        rc = 1'b1;
`endif
        w = 0;
        legal = 1'b1;
        if (op == int'(OP_NOP)) begin
            w = 0;
        end else if (op >= int'(OP_ADD) && op <= int'(OP_AND)) begin
            f7 = (op == int'(OP_SUB) || op == int'(OP_SRA)) ? 32 : 0;
            w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (r_f3[op - int'(OP_ADD)] << 12) | (rd << 7) | 32'h33;
        end else if (op >= int'(OP_ADDI) && op <= int'(OP_ANDI)) begin
            w = ((u % 4096) << 20) | (rs1 << 15) | (i_f3[op - int'(OP_ADDI)] << 12) | (rd << 7) | 32'h13;
            legal = !rc || (s >= -2048 && s <= 2047);
        end else if (op >= int'(OP_SLLI) && op <= int'(OP_SRAI)) begin
            f7 = (op == int'(OP_SRAI)) ? 32 : 0;
            w = (f7 << 25) | ((u % 32) << 20) | (rs1 << 15) | (i_f3[op - int'(OP_ADDI)] << 12) | (rd << 7) | 32'h13;
            legal = !rc || (u < 32);
        end else if (op >= int'(OP_LB) && op <= int'(OP_LHU)) begin
            w = ((u % 4096) << 20) | (rs1 << 15) | (ld_f3[op - int'(OP_LB)] << 12) | (rd << 7) | 32'h03;
            legal = !rc || (s >= -2048 && s <= 2047);
        end else if (op >= int'(OP_SB) && op <= int'(OP_SW)) begin
            w = (((u / 32) % 128) << 25) | (rs2 << 20) | (rs1 << 15) | ((op - int'(OP_SB)) << 12)
                | ((u % 32) << 7) | 32'h23;
            legal = !rc || (s >= -2048 && s <= 2047);
        end else if (op >= int'(OP_BEQ) && op <= int'(OP_BGEU)) begin
            w = (((u / 4096) % 2) << 31) | (((u / 32) % 64) << 25) | (rs2 << 20) | (rs1 << 15)
                | (br_f3[op - int'(OP_BEQ)] << 12) | (((u / 2) % 16) << 8) | (((u / 2048) % 2) << 7) | 32'h63;
            legal = !rc || (s >= -4096 && s <= 4094 && (u % 2) == 0);
        end else if (op == int'(OP_JAL)) begin
            w = (((u / 1048576) % 2) << 31) | (((u / 2) % 1024) << 21) | (((u / 2048) % 2) << 20)
                | (((u / 4096) % 256) << 12) | (rd << 7) | 32'h6F;
            legal = !rc || (s >= -1048576 && s <= 1048574 && (u % 2) == 0);
        end else if (op == int'(OP_LUI) || op == int'(OP_AUIPC)) begin
            w = (u - (u % 4096)) | (rd << 7) | ((op == int'(OP_LUI)) ? 32'h37 : 32'h17);
            legal = !rc || ((u % 4096) == 0);
        end else if (op == int'(OP_JALR)) begin
            w = ((u % 4096) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
            legal = !rc || (s >= -2048 && s <= 2047);
        end else begin
            legal = 1'b0;
        end
    endfunction

    // One clock cycle of stimulus followed by a full comparison of the outputs against the model.
    task automatic cyc(input bit v, input int op, input int rd, input int rs1, input int rs2,
                       input logic [31:0] imm, input bit st);
        int unsigned w;
        int          addr;
        bit          legal, rdy, xfer, we;
        @(negedge clock);
        req_valid = v;
        req_op    = 6'(op);
        req_rd    = 5'(rd);
        req_rs1   = 5'(rs1);
        req_rs2   = 5'(rs2);
        req_imm   = imm;
        start     = st;
        #1;
        rdy = (m_cnt != DEPTH) && !st;
        check("req_ready", 32'(req_ready), 32'(rdy));
        xfer = v && rdy;
        ref_encode(op, rd, rs1, rs2, imm, w, legal);
        we = 1'b0;
        addr = 0;
        if (st) begin
            m_ptr = BASE; m_cnt = 0; m_err = 1'b0;
        end else if (xfer) begin
            if (!legal) m_err = 1'b1;
            else begin
                we = 1'b1; addr = m_ptr; m_ptr++; m_cnt++;
            end
        end
        @(posedge clock);
        #1;
        check("mem_we", 32'(mem_we), 32'(we));
        if (we) begin
            check("mem_addr", 32'(mem_addr), 32'(addr));
            check("mem_wdata", mem_wdata, w);
        end
        check("count", 32'(count), 32'(m_cnt));
        check("full", 32'(full), 32'(m_cnt == DEPTH));
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic do_start();
        cyc(1'b0, 0, 0, 0, 0, 32'd0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rimm;
        int          rop;
        reset = 1'b1; start = 1'b0; req_valid = 1'b0; req_op = '0;
        req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        m_ptr = BASE; m_cnt = 0; m_err = 1'b0;
        @(posedge clock);
        #1;
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'(BASE));
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);

        // ADD x3, x1, x2
        cyc(1'b1, OP_ADD, 3, 1, 2, 32'd0, 1'b0);
        check("add_word", mem_wdata, 32'h002081B3);
        check("add_addr", 32'(mem_addr), 32'd0);
        check("add_count", 32'(count), 32'd1);

        // Back-to-back ADDI then SW
        do_start();
        cyc(1'b1, OP_ADDI, 5, 0, 0, 32'hFFFF_FFFF, 1'b0);
        check("addi_word", mem_wdata, 32'hFFF00293);
        cyc(1'b1, OP_SW, 0, 1, 2, 32'd8, 1'b0);
        check("sw_word", mem_wdata, 32'h0020A423);
        check("sw_addr", 32'(mem_addr), 32'd1);

        do_start();
        cyc(1'b1, OP_BEQ, 0, 0, 0, 32'hFFFF_FFFC, 1'b0);
        check("beq_word", mem_wdata, 32'hFE000EE3);
`ifdef RANGE_CHECK_EN
        cyc(1'b1, OP_BEQ, 0, 0, 0, 32'd3, 1'b0);
        check("beq_odd_err", 32'(err), 32'd1);
        check("beq_odd_nowe", 32'(mem_we), 32'd0);
        do_start();
        check("start_clears_err", 32'(err), 32'd0);
`else
        cyc(1'b1, OP_BEQ, 0, 0, 0, 32'd3, 1'b0);
        check("beq_trunc_word", mem_wdata, 32'h00000163);
`endif

        do_start();
        cyc(1'b1, OP_ADDI, 5, 0, 0, 32'd2048, 1'b0);
`ifdef RANGE_CHECK_EN
        check("addi2048_err", 32'(err), 32'd1);
        check("addi2048_count", 32'(count), 32'd0);
`else
        check("addi2048_word", mem_wdata, 32'h80000293);
`endif

        // Illegal op code sets err, no write; start clears it.
        do_start();
        cyc(1'b1, 45, 1, 2, 3, 32'd0, 1'b0);
        check("badop_err", 32'(err), 32'd1);
        do_start();

        // Fill to DEPTH with a fifth request held valid.
        for (int k = 1; k <= 4; k++) cyc(1'b1, OP_ADDI, 1, 0, 0, 32'(k), 1'b0);
        check("fill_full", 32'(full), 32'd1);
        cyc(1'b1, OP_ADDI, 1, 0, 0, 32'd5, 1'b0);
        cyc(1'b1, OP_ADDI, 1, 0, 0, 32'd5, 1'b0);
        check("stall_ready", 32'(req_ready), 32'd0);
        cyc(1'b1, OP_ADDI, 1, 0, 0, 32'd5, 1'b1);
        cyc(1'b1, OP_ADDI, 1, 0, 0, 32'd5, 1'b0);
        check("fifth_addr", 32'(mem_addr), 32'd0);
        check("fifth_word", mem_wdata, 32'h00500093);

        // Randomized traffic, restarting when full or after an error.
        for (int i = 0; i < 400; i++) begin
            rop = $urandom_range(0, 41);
            if ($urandom_range(0, 1) == 1) rimm = $urandom;
            else rimm = 32'($signed(int'($urandom_range(0, 8191)) - 4096));
            if (m_cnt == DEPTH || m_err || $urandom_range(0, 15) == 0)
                cyc(1'($urandom_range(0, 1)), rop, $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 31), rimm, 1'b1);
            else
                cyc($urandom_range(0, 3) != 0, rop, $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 31), rimm, 1'b0);
        end

        // Reset asserted during the stage-2 cycle of a write.
        do_start();
        cyc(1'b1, OP_ADD, 3, 1, 2, 32'd0, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_we", 32'(mem_we), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_addr", 32'(mem_addr), 32'(BASE));
        @(negedge clock);
        req_valid = 1'b0;
        reset = 1'b0;
        m_ptr = BASE; m_cnt = 0; m_err = 1'b0;
        cyc(1'b0, 0, 0, 0, 0, 32'd0, 1'b0);
        cyc(1'b1, OP_LUI, 7, 0, 0, 32'h12345000, 1'b0);
        check("lui_after_rst", mem_wdata, 32'h123453B7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
